debouncer_multi: RTL and testbench

DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

---
 rtl/debouncer_multi.sv | 104 ++++++++++
 tb/tb_debouncer_multi.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// Multi-channel switch debouncer: 2-flop sync, tick-sampled stable filter, rise/fall/long-press pulses.
// Latency 2 + up to STABLE_SAMPLES*TICK_DIV cycles din->level; no backpressure, pulses are fire-and-forget.
module debouncer_multi #(
   parameter int CHANNELS       = 4,
   parameter int TICK_DIV       = 20,
   parameter int STABLE_SAMPLES = 3,
   parameter int HOLD_TICKS     = 50
) (
   input  logic                sysclk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] din,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] long_press,
   output logic                tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = ($clog2(HOLD_TICKS + 1) > 0) ? $clog2(HOLD_TICKS + 1) : 1;
   localparam int SS = STABLE_SAMPLES;

   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
   localparam logic [HW-1:0] HOLD_PRE  = HW'(HOLD_TICKS - 1);

   logic [CW-1:0]       tick_cnt;
   logic [CHANNELS-1:0] sync_meta;
   logic [CHANNELS-1:0] sync_q;
   logic [SS-1:0]       samp      [CHANNELS];
   logic [SS-1:0]       samp_next [CHANNELS];
   logic [HW-1:0]       hold      [CHANNELS];

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
      end else begin
         tick <= (tick_cnt == TICK_LAST);
         if (tick_cnt == TICK_LAST)
            tick_cnt <= '0;
         else
            tick_cnt <= tick_cnt + CW'(1);
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         sync_meta <= '0;
         sync_q    <= '0;
      end else begin
         sync_meta <= din;
         sync_q    <= sync_meta;
      end
   end

   // Post-shift view of the sample window, so the decision sees the newest sample.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++)
         samp_next[i] = {samp[i][SS-2:0], sync_q[i]};
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         level      <= '0;
         rise       <= '0;
         fall       <= '0;
         long_press <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            samp[i] <= '0;
            hold[i] <= '0;
         end
      end else begin
         rise       <= '0;
         fall       <= '0;
         long_press <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            if (!level[i] && !tick) begin
               hold[i] <= '0;
            end
            if (tick) begin
               samp[i] <= samp_next[i];
               if ((&samp_next[i]) && !level[i]) begin
                  level[i] <= 1'b1;
                  rise[i]  <= 1'b1;
                  hold[i]  <= '0;
               end else if (!(|samp_next[i]) && level[i]) begin
                  level[i] <= 1'b0;
                  fall[i]  <= 1'b1;
                  hold[i]  <= '0;
               end else if (!level[i]) begin
                  hold[i] <= '0;
               end else if (hold[i] != HOLD_MAX) begin
                  // Saturating count means the pulse can only fire once per high period.
                  hold[i] <= hold[i] + HW'(1);
                  if (hold[i] == HOLD_PRE)
                     long_press[i] <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi with CHANNELS=4, TICK_DIV=4, STABLE_SAMPLES=3, HOLD_TICKS=5.
module tb_debouncer_multi;

   logic       sysclk = 1'b0;
   logic       reset  = 1'b0;
   logic [3:0] din    = 4'h0;
   logic [3:0] level, rise, fall, long_press;
   logic       tick;

   int tests = 0;
   int fails = 0;
   int n     = 0;
   int tick_dbl = 0;
   logic prev_tick = 1'b0;
   int rise_cnt [4];
   int fall_cnt [4];
   int lp_cnt   [4];
   int rise_at  [4];
   int lp_at    [4];

   debouncer_multi #(
      .CHANNELS      (4),
      .TICK_DIV      (4),
      .STABLE_SAMPLES(3),
      .HOLD_TICKS    (5)
   ) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .din       (din),
      .level     (level),
      .rise      (rise),
      .fall      (fall),
      .long_press(long_press),
      .tick      (tick)
   );

   always #5 sysclk = ~sysclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_counts();
      n         = 0;
      tick_dbl  = 0;
      prev_tick = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rise_cnt[i] = 0;
         fall_cnt[i] = 0;
         lp_cnt[i]   = 0;
         rise_at[i]  = -1;
         lp_at[i]    = -1;
      end
   endtask

   task automatic step();
      @(posedge sysclk);
      #1;
      n++;
      if (tick && prev_tick) tick_dbl++;
      prev_tick = tick;
      for (int i = 0; i < 4; i++) begin
         if (rise[i]) begin rise_cnt[i]++; rise_at[i] = n; end
         if (fall[i]) fall_cnt[i]++;
         if (long_press[i]) begin lp_cnt[i]++; lp_at[i] = n; end
      end
   endtask

   task automatic step_to(input int target);
      while (n < target) step();
   endtask

   initial begin
      clear_counts();
      reset = 1'b0;
      din   = 4'h0;
      repeat (3) @(posedge sysclk);
      #1;
      check("reset_state", {15'd0, level, rise, fall, long_press, tick}, 32'h0);

      @(negedge sysclk);
      reset = 1'b1;
      clear_counts();

      // Tick phase, with a clean press started on channel 0 after cycle 4.
      for (int c = 1; c <= 12; c++) begin
         step();
         check($sformatf("tick_c%0d", c), {31'd0, tick}, (n % 4 == 0) ? 32'h1 : 32'h0);
         if (n == 4) din[0] = 1'b1;
      end

      step_to(16);
      check("press0_level_before", {28'd0, level}, 32'h0);
      step_to(17);
      check("press0_level", {28'd0, level}, 32'h1);
      check("press0_rise", {28'd0, rise}, 32'h1);
      check("press0_fall", {28'd0, fall}, 32'h0);
      step();
      check("press0_rise_single", {28'd0, rise}, 32'h0);

      step_to(20);
      din[1] = 1'b1;
      step_to(25);
      din[1] = 1'b0;
      step_to(28);
      din[2] = 1'b1;

      step_to(37);
      check("long0_pulse", {28'd0, long_press}, 32'h1);
      step_to(40);
      check("glitch1_level", {28'd0, level}, 32'h1);
      check("glitch1_rise_cnt", rise_cnt[1], 32'd0);
      check("glitch1_fall_cnt", fall_cnt[1], 32'd0);

      step_to(41);
      check("press2_rise", {28'd0, rise}, 32'h4);
      step_to(60);
      check("long2_not_early", lp_cnt[2], 32'd0);
      step_to(61);
      check("long2_pulse", {28'd0, long_press}, 32'h4);
      check("long2_delay", lp_at[2] - rise_at[2], 32'd20);

      step_to(70);
      din[2] = 1'b0;
      step_to(81);
      check("release2_fall", {28'd0, fall}, 32'h4);
      check("release2_level", {28'd0, level}, 32'h1);

      step_to(84);
      din[3] = 1'b1;
      step_to(97);
      check("press3_rise", {28'd0, rise}, 32'h8);
      step_to(98);
      din[3] = 1'b0;
      step_to(109);
      check("short3_fall", {28'd0, fall}, 32'h8);
      check("short3_level", {28'd0, level}, 32'h1);

      step_to(112);
      din = 4'hF;
      step_to(125);
      check("multi_rise", {28'd0, rise}, 32'hE);
      check("multi_level", {28'd0, level}, 32'hF);
      step_to(127);
      check("long2_once", lp_cnt[2], 32'd1);
      check("long3_none", lp_cnt[3], 32'd0);
      check("long0_once", lp_cnt[0], 32'd1);
      check("ch0_rise_once", rise_cnt[0], 32'd1);
      check("ch0_no_fall", fall_cnt[0], 32'd0);
      check("tick_no_double", tick_dbl, 32'd0);

      // Asynchronous reset between clock edges.
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_outputs", {15'd0, level, rise, fall, long_press, tick}, 32'h0);
      repeat (3) @(posedge sysclk);
      @(negedge sysclk);
      reset = 1'b1;
      clear_counts();

      step_to(12);
      check("rerelease_level_before", {28'd0, level}, 32'h0);
      check("rerelease_no_pulse", rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3], 32'd0);
      step_to(13);
      check("rerelease_rise", {28'd0, rise}, 32'hF);
      check("rerelease_level", {28'd0, level}, 32'hF);
      step_to(32);
      check("rerelease_long_not_early", lp_cnt[0] + lp_cnt[1] + lp_cnt[2] + lp_cnt[3], 32'd0);
      step_to(33);
      check("rerelease_long", {28'd0, long_press}, 32'hF);
      step_to(45);
      check("rerelease_long_once", lp_cnt[0] + lp_cnt[1] + lp_cnt[2] + lp_cnt[3], 32'd4);
      check("rerelease_no_fall", fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3], 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
